// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/memory-stage port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } arb_state_e;

    typedef enum logic {
        OwnI,
        OwnD
    } arb_owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response and backing-memory signals of the port arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    logic                   i_req_valid;
    logic [AddrWidth-1:0]   i_req_addr;
    logic                   i_req_ready;
    logic                   i_rsp_valid;
    logic [DataWidth-1:0]   i_rsp_data;

    logic                   d_req_valid;
    logic                   d_req_we;
    logic [AddrWidth-1:0]   d_req_addr;
    logic [DataWidth-1:0]   d_req_wdata;
    logic [DataWidth/8-1:0] d_req_be;
    logic                   d_req_ready;
    logic                   d_rsp_valid;
    logic [DataWidth-1:0]   d_rsp_data;

    logic                   mem_req;
    logic                   mem_we;
    logic [AddrWidth-1:0]   mem_addr;
    logic [DataWidth-1:0]   mem_wdata;
    logic [DataWidth/8-1:0] mem_be;
    logic                   mem_gnt;
    logic                   mem_rvalid;
    logic [DataWidth-1:0]   mem_rdata;

    logic                   stall_f;
    logic                   stall_m;

    // Arbiter side.
    modport slave (
        input  i_req_valid, i_req_addr,
        input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_be,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output i_req_ready, i_rsp_valid, i_rsp_data,
        output d_req_ready, d_rsp_valid, d_rsp_data,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output stall_f, stall_m
    );

    // Requester/memory side.
    modport master (
        output i_req_valid, i_req_addr,
        output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_be,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  i_req_ready, i_rsp_valid, i_rsp_data,
        input  d_req_ready, d_rsp_valid, d_rsp_data,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  stall_f, stall_m
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (I) and memory stage (D), one transaction
// at a time; D has priority, with a starvation guard that eventually forces an I grant.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned StarveLimit = 4
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned BeWidth = DataWidth / 8;
    localparam int unsigned CntW    = $clog2(StarveLimit + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(StarveLimit);

    arb_state_e           state_q;
    arb_owner_e           owner_q;
    logic [CntW-1:0]      starve_q;
    logic                 we_q;
    logic [AddrWidth-1:0] addr_q;
    logic [DataWidth-1:0] wdata_q;
    logic [BeWidth-1:0]   be_q;
    logic                 i_rsp_valid_q;
    logic [DataWidth-1:0] i_rsp_data_q;
    logic                 d_rsp_valid_q;
    logic [DataWidth-1:0] d_rsp_data_q;

    logic starved;
    logic grant_i;
    logic grant_d;

    always_comb begin
        starved = (starve_q == CntMax);
        grant_i = (state_q == StIdle) && bus.i_req_valid && (!bus.d_req_valid || starved);
        grant_d = (state_q == StIdle) && bus.d_req_valid && !grant_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            owner_q       <= OwnI;
            starve_q      <= '0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            i_rsp_valid_q <= 1'b0;
            i_rsp_data_q  <= '0;
            d_rsp_valid_q <= 1'b0;
            d_rsp_data_q  <= '0;
        end else begin
            i_rsp_valid_q <= 1'b0;
            d_rsp_valid_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (grant_i) begin
                        owner_q <= OwnI;
                        we_q    <= 1'b0;
                        addr_q  <= bus.i_req_addr;
                        wdata_q <= '0;
                        be_q    <= '1;
                        state_q <= StIssue;
                    end else if (grant_d) begin
                        owner_q <= OwnD;
                        we_q    <= bus.d_req_we;
                        addr_q  <= bus.d_req_addr;
                        wdata_q <= bus.d_req_wdata;
                        be_q    <= bus.d_req_be;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    if (bus.mem_gnt) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (bus.mem_rvalid) begin
                        state_q <= StIdle;
                        if (owner_q == OwnI) begin
                            i_rsp_valid_q <= 1'b1;
                            i_rsp_data_q  <= bus.mem_rdata;
                        end else begin
                            d_rsp_valid_q <= 1'b1;
                            d_rsp_data_q  <= we_q ? '0 : bus.mem_rdata;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Counts D wins over a waiting I; any idle cycle without an I request forgives.
            if (state_q == StIdle) begin
                if (grant_i || !bus.i_req_valid) begin
                    starve_q <= '0;
                end else if (grant_d && !starved) begin
                    starve_q <= starve_q + CntW'(1);
                end
            end
        end
    end

    assign bus.i_req_ready = grant_i;
    assign bus.d_req_ready = grant_d;
    assign bus.i_rsp_valid = i_rsp_valid_q;
    assign bus.i_rsp_data  = i_rsp_data_q;
    assign bus.d_rsp_valid = d_rsp_valid_q;
    assign bus.d_rsp_data  = d_rsp_data_q;

    assign bus.mem_req   = (state_q == StIssue);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;

    assign bus.stall_f = (bus.i_req_valid || (owner_q == OwnI && state_q != StIdle))
                         && !i_rsp_valid_q;
    assign bus.stall_m = (bus.d_req_valid || (owner_q == OwnD && state_q != StIdle))
                         && !d_rsp_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

    localparam int Limit = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AddrWidth(32), .DataWidth(32)) bus ();

    mem_port_arbiter #(
        .AddrWidth  (32),
        .DataWidth  (32),
        .StarveLimit(Limit)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          is_i;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rsp;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] ref_mem[256];
    logic [31:0] store[256];
    int          rs_phase;
    int          rs_cnt;
    bit          rs_we;
    logic [31:0] rs_addr;
    logic [31:0] rs_wdata;
    logic [3:0]  rs_be;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_req_valid = 1'b0;
        bus.i_req_addr  = '0;
        bus.d_req_valid = 1'b0;
        bus.d_req_we    = 1'b0;
        bus.d_req_addr  = '0;
        bus.d_req_wdata = '0;
        bus.d_req_be    = '0;
        bus.mem_gnt     = 1'b0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = '0;
    endtask

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        cyc();
        cyc();
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%0b exp=0", bus.mem_req); end
        checks++; if (bus.i_rsp_valid !== 1'b0 || bus.d_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got i=%0b d=%0b exp 0 0", bus.i_rsp_valid, bus.d_rsp_valid); end
        checks++; if (bus.mem_addr !== 32'h0 || bus.mem_be !== 4'h0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_fields got addr=%h be=%b we=%b exp 0", bus.mem_addr, bus.mem_be, bus.mem_we); end
        checks++; if (bus.stall_f !== 1'b0 || bus.stall_m !== 1'b0) begin errors++; $display("FAIL reset_stall_idle got f=%0b m=%0b exp 0 0", bus.stall_f, bus.stall_m); end
        bus.d_req_valid = 1'b1;
        #1;
        checks++; if (bus.stall_m !== 1'b1) begin errors++; $display("FAIL reset_stall_m_follows got=%0b exp=1", bus.stall_m); end
        bus.d_req_valid = 1'b0;
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_i_read(input logic [31:0] addr, input logic [31:0] data);
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = addr;
        #1;
        checks++; if (bus.i_req_ready !== 1'b1 || bus.d_req_ready !== 1'b0) begin errors++; $display("FAIL iread_ready got i=%0b d=%0b exp 1 0", bus.i_req_ready, bus.d_req_ready); end
        checks++; if (bus.stall_f !== 1'b1) begin errors++; $display("FAIL iread_stall_req got=%0b exp=1", bus.stall_f); end
        cyc();
        bus.i_req_valid = 1'b0;
        bus.i_req_addr  = 32'h0BAD0BAD;
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== addr || bus.mem_we !== 1'b0) begin errors++; $display("FAIL iread_issue got req=%0b addr=%h we=%0b exp 1 %h 0", bus.mem_req, bus.mem_addr, bus.mem_we, addr); end
        bus.mem_gnt = 1'b1;
        cyc();
        bus.mem_gnt = 1'b0;
        checks++; if (bus.mem_req !== 1'b0 || bus.stall_f !== 1'b1) begin errors++; $display("FAIL iread_wait got req=%0b stall_f=%0b exp 0 1", bus.mem_req, bus.stall_f); end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = data;
        cyc();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        checks++; if (bus.i_rsp_valid !== 1'b1 || bus.i_rsp_data !== data || bus.d_rsp_valid !== 1'b0) begin errors++; $display("FAIL iread_rsp got v=%0b data=%h dv=%0b exp 1 %h 0", bus.i_rsp_valid, bus.i_rsp_data, bus.d_rsp_valid, data); end
        #1;
        checks++; if (bus.stall_f !== 1'b0) begin errors++; $display("FAIL iread_stall_release got=%0b exp=0", bus.stall_f); end
        cyc();
        checks++; if (bus.i_rsp_valid !== 1'b0) begin errors++; $display("FAIL iread_rsp_pulse got=%0b exp=0", bus.i_rsp_valid); end
    endtask

    task automatic test_reset_mid();
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = 32'h180;
        cyc();
        bus.i_req_valid = 1'b0;
        bus.mem_gnt     = 1'b1;
        cyc();
        bus.mem_gnt = 1'b0;
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h55AA55AA;
        cyc();
        bus.mem_rvalid = 1'b0;
        checks++; if (bus.i_rsp_valid !== 1'b0 || bus.d_rsp_valid !== 1'b0 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_late_rvalid got iv=%0b dv=%0b req=%0b exp 0 0 0", bus.i_rsp_valid, bus.d_rsp_valid, bus.mem_req); end
        cyc();
        test_i_read(32'h104, 32'hCAFEF00D);
    endtask

    task automatic test_both_valid();
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = 32'h80;
        bus.d_req_valid = 1'b1;
        bus.d_req_we    = 1'b0;
        bus.d_req_addr  = 32'h40;
        #1;
        checks++; if (bus.d_req_ready !== 1'b1 || bus.i_req_ready !== 1'b0) begin errors++; $display("FAIL both_first_grant got i=%0b d=%0b exp 0 1", bus.i_req_ready, bus.d_req_ready); end
        cyc();
        bus.d_req_valid = 1'b0;
        checks++; if (bus.mem_addr !== 32'h40 || bus.stall_f !== 1'b1) begin errors++; $display("FAIL both_d_issue got addr=%h stall_f=%0b exp 40 1", bus.mem_addr, bus.stall_f); end
        bus.mem_gnt = 1'b1;
        cyc();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h11112222;
        cyc();
        bus.mem_rvalid = 1'b0;
        checks++; if (bus.d_rsp_valid !== 1'b1 || bus.d_rsp_data !== 32'h11112222 || bus.i_rsp_valid !== 1'b0) begin errors++; $display("FAIL both_d_rsp got dv=%0b data=%h iv=%0b exp 1 11112222 0", bus.d_rsp_valid, bus.d_rsp_data, bus.i_rsp_valid); end
        #1;
        checks++; if (bus.i_req_ready !== 1'b1 || bus.stall_f !== 1'b1) begin errors++; $display("FAIL both_i_at_t3 got ready=%0b stall_f=%0b exp 1 1", bus.i_req_ready, bus.stall_f); end
        cyc();
        bus.i_req_valid = 1'b0;
        checks++; if (bus.mem_addr !== 32'h80 || bus.stall_f !== 1'b1) begin errors++; $display("FAIL both_i_issue got addr=%h stall_f=%0b exp 80 1", bus.mem_addr, bus.stall_f); end
        bus.mem_gnt = 1'b1;
        cyc();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h33334444;
        checks++; if (bus.stall_f !== 1'b1) begin errors++; $display("FAIL both_i_wait_stall got=%0b exp=1", bus.stall_f); end
        cyc();
        bus.mem_rvalid = 1'b0;
        checks++; if (bus.i_rsp_valid !== 1'b1 || bus.i_rsp_data !== 32'h33334444 || bus.stall_f !== 1'b0) begin errors++; $display("FAIL both_i_rsp got v=%0b data=%h stall_f=%0b exp 1 33334444 0", bus.i_rsp_valid, bus.i_rsp_data, bus.stall_f); end
        cyc();
    endtask

    task automatic test_d_write();
        bus.d_req_valid = 1'b1;
        bus.d_req_we    = 1'b1;
        bus.d_req_addr  = 32'h200;
        bus.d_req_wdata = 32'h1234;
        bus.d_req_be    = 4'b0011;
        #1;
        checks++; if (bus.d_req_ready !== 1'b1) begin errors++; $display("FAIL dwr_ready got=%0b exp=1", bus.d_req_ready); end
        cyc();
        bus.d_req_valid = 1'b0;
        bus.d_req_we    = 1'b0;
        bus.d_req_wdata = 32'hFFFF;
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h200 || bus.mem_wdata !== 32'h1234 || bus.mem_be !== 4'b0011) begin errors++; $display("FAIL dwr_fields got we=%0b addr=%h wdata=%h be=%b exp 1 200 1234 0011", bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be); end
        bus.mem_gnt = 1'b1;
        cyc();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hFFFFFFFF;
        cyc();
        bus.mem_rvalid = 1'b0;
        checks++; if (bus.d_rsp_valid !== 1'b1 || bus.d_rsp_data !== 32'h0 || bus.i_rsp_valid !== 1'b0) begin errors++; $display("FAIL dwr_rsp got dv=%0b data=%h iv=%0b exp 1 0 0", bus.d_rsp_valid, bus.d_rsp_data, bus.i_rsp_valid); end
        cyc();
    endtask

    task automatic test_gnt_delay();
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = 32'h300;
        #1;
        checks++; if (bus.i_req_ready !== 1'b1) begin errors++; $display("FAIL gdly_ready got=%0b exp=1", bus.i_req_ready); end
        cyc();
        bus.i_req_valid = 1'b0;
        bus.i_req_addr  = 32'h3FC;
        bus.d_req_valid = 1'b1;
        bus.d_req_we    = 1'b0;
        bus.d_req_addr  = 32'h44;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h300 || bus.mem_we !== 1'b0 || bus.stall_f !== 1'b1 || bus.d_req_ready !== 1'b0) begin errors++; $display("FAIL gdly_hold cyc=%0d got req=%0b addr=%h we=%0b stall_f=%0b dready=%0b exp 1 300 0 1 0", k, bus.mem_req, bus.mem_addr, bus.mem_we, bus.stall_f, bus.d_req_ready); end
            if (k == 3) bus.mem_gnt = 1'b1;
            cyc();
        end
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h77778888;
        cyc();
        bus.mem_rvalid = 1'b0;
        checks++; if (bus.i_rsp_valid !== 1'b1 || bus.i_rsp_data !== 32'h77778888) begin errors++; $display("FAIL gdly_rsp got v=%0b data=%h exp 1 77778888", bus.i_rsp_valid, bus.i_rsp_data); end
        #1;
        checks++; if (bus.d_req_ready !== 1'b1) begin errors++; $display("FAIL gdly_d_after got=%0b exp=1", bus.d_req_ready); end
        cyc();
        bus.d_req_valid = 1'b0;
        bus.mem_gnt     = 1'b1;
        cyc();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h9999AAAA;
        cyc();
        bus.mem_rvalid = 1'b0;
        checks++; if (bus.d_rsp_valid !== 1'b1 || bus.d_rsp_data !== 32'h9999AAAA) begin errors++; $display("FAIL gdly_d_rsp got v=%0b data=%h exp 1 9999aaaa", bus.d_rsp_valid, bus.d_rsp_data); end
        cyc();
    endtask

    task automatic test_starvation();
        bit exp_i;
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = 32'h500;
        bus.d_req_valid = 1'b1;
        bus.d_req_we    = 1'b0;
        bus.d_req_addr  = 32'h600;
        for (int k = 0; k < 6; k++) begin
            #1;
            exp_i = (k == Limit);
            checks++; if (bus.i_req_ready !== exp_i || bus.d_req_ready !== !exp_i) begin errors++; $display("FAIL starve_grant n=%0d got i=%0b d=%0b exp i=%0b d=%0b", k, bus.i_req_ready, bus.d_req_ready, exp_i, !exp_i); end
            cyc();
            bus.mem_gnt = 1'b1;
            cyc();
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 32'(k);
            cyc();
            bus.mem_rvalid = 1'b0;
            checks++; if (bus.i_rsp_valid !== exp_i || bus.d_rsp_valid !== !exp_i) begin errors++; $display("FAIL starve_rsp n=%0d got i=%0b d=%0b exp i=%0b d=%0b", k, bus.i_rsp_valid, bus.d_rsp_valid, exp_i, !exp_i); end
        end
        bus.i_req_valid = 1'b0;
        bus.d_req_valid = 1'b0;
        cyc();
    endtask

    // Behavioural memory: random grant and completion latency.
    task automatic mem_step();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        if (rs_phase == 0) begin
            if (bus.mem_req) begin
                if (rs_cnt == 0) begin
                    bus.mem_gnt = 1'b1;
                    rs_phase    = 1;
                    rs_we       = bus.mem_we;
                    rs_addr     = bus.mem_addr;
                    rs_wdata    = bus.mem_wdata;
                    rs_be       = bus.mem_be;
                    rs_cnt      = int'($urandom_range(0, 2));
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++; $display("FAIL rand_mem_req_unexpected got addr=%h exp no request", bus.mem_addr);
                    end else if (bus.mem_addr !== exp_q[0].addr || bus.mem_we !== exp_q[0].we || (exp_q[0].we && (bus.mem_wdata !== exp_q[0].wdata || bus.mem_be !== exp_q[0].be))) begin
                        errors++; $display("FAIL rand_mem_fields got addr=%h we=%0b wdata=%h be=%b exp %h %0b %h %b", bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.mem_be, exp_q[0].addr, exp_q[0].we, exp_q[0].wdata, exp_q[0].be);
                    end
                end else begin
                    rs_cnt--;
                end
            end
        end else begin
            if (rs_cnt == 0) begin
                bus.mem_rvalid = 1'b1;
                if (rs_we) begin
                    store[rs_addr[9:2]] = merge(store[rs_addr[9:2]], rs_wdata, rs_be);
                    bus.mem_rdata = $urandom;
                end else begin
                    bus.mem_rdata = store[rs_addr[9:2]];
                end
                rs_phase = 0;
                rs_cnt   = int'($urandom_range(0, 2));
            end else begin
                rs_cnt--;
            end
        end
    endtask

    task automatic test_random();
        int          streak = 0;
        bit          busy = 0;
        bit          own_i = 0;
        bit          i_acc = 0;
        bit          d_acc = 0;
        bit          exp_ir, exp_dr, exp_sf, exp_sm;
        logic [31:0] got_data;
        txn_t        t;
        for (int w = 0; w < 256; w++) begin
            ref_mem[w] = $urandom;
            store[w]   = ref_mem[w];
        end
        rs_phase = 0;
        rs_cnt   = 0;
        for (int n = 0; n < 1800; n++) begin
            @(posedge clk);
            #1;
            if (i_acc) bus.i_req_valid = 1'b0;
            if (d_acc) bus.d_req_valid = 1'b0;
            i_acc = 0;
            d_acc = 0;
            if (bus.i_rsp_valid || bus.d_rsp_valid) begin
                checks++;
                if (exp_q.size() == 0 || (bus.i_rsp_valid && bus.d_rsp_valid)) begin
                    errors++; $display("FAIL rand_rsp_unexpected got iv=%0b dv=%0b exp one rsp for %0d pending", bus.i_rsp_valid, bus.d_rsp_valid, exp_q.size());
                end else begin
                    t = exp_q.pop_front();
                    got_data = bus.i_rsp_valid ? bus.i_rsp_data : bus.d_rsp_data;
                    if (bus.i_rsp_valid !== t.is_i || got_data !== t.rsp) begin
                        errors++; $display("FAIL rand_rsp got is_i=%0b data=%h exp is_i=%0b data=%h", bus.i_rsp_valid, got_data, t.is_i, t.rsp);
                    end
                end
                busy = 0;
            end
            mem_step();
            if (n < 1500) begin
                if (!bus.i_req_valid && $urandom_range(0, 99) < 40) begin
                    bus.i_req_valid = 1'b1;
                    bus.i_req_addr  = {22'd0, 8'($urandom), 2'b00};
                end
                if (!bus.d_req_valid && $urandom_range(0, 99) < 40) begin
                    bus.d_req_valid = 1'b1;
                    bus.d_req_we    = 1'($urandom);
                    bus.d_req_addr  = {22'd0, 8'($urandom), 2'b00};
                    bus.d_req_wdata = $urandom;
                    bus.d_req_be    = 4'($urandom_range(1, 15));
                end
            end
            #1;
            exp_ir = 0;
            exp_dr = 0;
            if (!busy) begin
                if (bus.i_req_valid && (!bus.d_req_valid || streak >= Limit)) exp_ir = 1;
                else if (bus.d_req_valid) exp_dr = 1;
            end
            checks++; if (bus.i_req_ready !== exp_ir || bus.d_req_ready !== exp_dr) begin errors++; $display("FAIL rand_ready cyc=%0d got i=%0b d=%0b exp i=%0b d=%0b", n, bus.i_req_ready, bus.d_req_ready, exp_ir, exp_dr); end
            exp_sf = (bus.i_req_valid || (busy && own_i)) && !bus.i_rsp_valid;
            exp_sm = (bus.d_req_valid || (busy && !own_i)) && !bus.d_rsp_valid;
            checks++; if (bus.stall_f !== exp_sf || bus.stall_m !== exp_sm) begin errors++; $display("FAIL rand_stall cyc=%0d got f=%0b m=%0b exp f=%0b m=%0b", n, bus.stall_f, bus.stall_m, exp_sf, exp_sm); end
            if (!busy) begin
                if (exp_ir) streak = 0;
                else if (exp_dr && bus.i_req_valid) streak = (streak < Limit) ? streak + 1 : Limit;
                else if (!bus.i_req_valid) streak = 0;
            end
            i_acc = bus.i_req_valid && bus.i_req_ready;
            d_acc = bus.d_req_valid && bus.d_req_ready;
            if (i_acc) begin
                t.is_i = 1; t.we = 0; t.addr = bus.i_req_addr; t.wdata = '0; t.be = '0;
                t.rsp = ref_mem[bus.i_req_addr[9:2]];
                exp_q.push_back(t);
                busy = 1; own_i = 1;
            end else if (d_acc) begin
                t.is_i = 0; t.we = bus.d_req_we; t.addr = bus.d_req_addr;
                t.wdata = bus.d_req_wdata; t.be = bus.d_req_be;
                if (bus.d_req_we) begin
                    t.rsp = '0;
                    ref_mem[bus.d_req_addr[9:2]] = merge(ref_mem[bus.d_req_addr[9:2]], bus.d_req_wdata, bus.d_req_be);
                end else begin
                    t.rsp = ref_mem[bus.d_req_addr[9:2]];
                end
                exp_q.push_back(t);
                busy = 1; own_i = 0;
            end
        end
        checks++; if (exp_q.size() != 0 || busy || bus.i_req_valid || bus.d_req_valid) begin errors++; $display("FAIL rand_drain got pending=%0d busy=%0b iv=%0b dv=%0b exp 0 0 0 0", exp_q.size(), busy, bus.i_req_valid, bus.d_req_valid); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_i_read(32'h100, 32'hDEADBEEF);
        test_reset_mid();
        test_both_valid();
        test_d_write();
        test_gnt_delay();
        test_starvation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
